pipe_skid_stage: RTL and testbench

Parametrised elastic pipeline register for inter-stage boundaries (F/D, D/E, E/M, M/W) of the RV64I pipeline. It replaces the enable/clear style stage register with a valid/ready handshake and a 2-entry skid buffer. This keeps full throughput while cutting the combinational ready path between stages. It also supports synchronous flush for branch misprediction and carries a saturating back-pressure counter for performance analysis.

---
 rtl/pipe_skid_stage.sv | 94 +++++++++
 tb/tb_pipe_skid_stage.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/pipe_skid_stage.sv
// Elastic pipeline register: valid/ready handshake with a 2-entry skid buffer,
// synchronous flush and a saturating back-pressure counter.
module pipe_skid_stage #(
    parameter int                DATA_W = 96,
    parameter logic [DATA_W-1:0] BUBBLE = '0,
    parameter int                CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              main_v_q, main_v_d;
    logic              skid_v_q, skid_v_d;
    logic              in_ready_q;
    logic [CNT_W-1:0]  stall_q, stall_d;

    logic in_fire, out_fire;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = main_v_q & out_ready;

    always_comb begin
        main_d   = main_q;
        skid_d   = skid_q;
        main_v_d = main_v_q;
        skid_v_d = skid_v_q;
        stall_d  = (main_v_q & ~out_ready) ? sat_inc(stall_q) : stall_q;

        if (flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (!main_v_q) begin
            if (in_fire) begin
                main_v_d = 1'b1;
                main_d   = in_data;
            end
        end else if (!skid_v_q) begin
            if (in_fire && out_fire) begin
                main_d = in_data;
            end else if (in_fire) begin
                skid_v_d = 1'b1;
                skid_d   = in_data;
            end else if (out_fire) begin
                main_v_d = 1'b0;
            end
        end else if (out_fire) begin
            // Full: in_ready is low, so only a drain can happen; skid moves up.
            main_d   = skid_q;
            skid_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_v_q   <= 1'b0;
            skid_v_q   <= 1'b0;
            in_ready_q <= 1'b1;
            stall_q    <= '0;
        end else begin
            main_v_q   <= main_v_d;
            skid_v_q   <= skid_v_d;
            in_ready_q <= ~skid_v_d;
            stall_q    <= stall_d;
        end
    end

    // Payload storage carries no reset; validity is tracked by the bits above.
    always_ff @(posedge clk) begin
        main_q <= main_d;
        skid_q <= skid_d;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_v_q;
    assign out_data  = main_v_q ? main_q : BUBBLE;
    assign occupancy = {1'b0, main_v_q} + {1'b0, skid_v_q};
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Randomised and directed bench for pipe_skid_stage against a queue-based
// reference model of the stage's FIFO behaviour.
module tb_pipe_skid_stage;

    localparam int          DATA_W = 16;
    localparam int          CNT_W  = 4;
    localparam logic [15:0] BUB    = 16'hDEAD;
    localparam int          SAT    = 15;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cnt;

    pipe_skid_stage #(.DATA_W(DATA_W), .BUBBLE(BUB), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DATA_W-1:0] mq[$];
    int                mstall = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        int sz;
        sz = mq.size();
        check("out_valid", 64'(out_valid), 64'(sz > 0));
        check("out_data",  64'(out_data),  64'((sz > 0) ? mq[0] : BUB));
        check("in_ready",  64'(in_ready),  64'(sz < 2));
        check("occupancy", 64'(occupancy), 64'(sz));
        check("stall_cnt", 64'(stall_cnt), 64'(mstall));
    endtask

    // One cycle: check state left by the previous edge, then apply inputs for the next edge.
    task automatic step(input logic iv, input logic [DATA_W-1:0] d, input logic ordy, input logic fl);
        logic inf, outf;
        @(negedge clk);
        check_outputs();
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        inf  = iv && (mq.size() < 2);
        outf = (mq.size() > 0) && ordy;
        if ((mq.size() > 0) && !ordy && mstall < SAT) mstall++;
        if (fl) begin
            mq.delete();
        end else begin
            if (outf) void'(mq.pop_front());
            if (inf)  mq.push_back(d);
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data",  64'(out_data),  64'(BUB));
        check("rst_in_ready",  64'(in_ready),  64'(1));
        check("rst_occupancy", 64'(occupancy), 64'(0));
        check("rst_stall_cnt", 64'(stall_cnt), 64'(0));
        rst = 1'b0;

        // Streaming 0x1..0x8 with the sink always ready
        for (int i = 1; i <= 8; i++) step(1'b1, DATA_W'(i), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++)  step(1'b0, '0, 1'b1, 1'b0);

        // Skid fill with a stalled sink, then drain in order
        step(1'b1, 16'h000A, 1'b0, 1'b0);
        step(1'b1, 16'h000B, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);

        // Flush while full together with an accepted-looking input
        step(1'b1, 16'h000A, 1'b0, 1'b0);
        step(1'b1, 16'h000B, 1'b0, 1'b0);
        step(1'b1, 16'h000C, 1'b0, 1'b1);
        step(1'b1, 16'h000D, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);

        // Counter saturation: hold a valid output stalled for 20 cycles
        step(1'b1, 16'h0055, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b0, 1'b0);
        check("stall_sat", 64'(stall_cnt), 64'(SAT));

        // Asynchronous reset mid-stream with two entries held
        step(1'b1, 16'h0077, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        check_outputs();
        check("pre_rst_occupancy", 64'(occupancy), 64'(2));
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'(0));
        check("mid_rst_out_data",  64'(out_data),  64'(BUB));
        check("mid_rst_in_ready",  64'(in_ready),  64'(1));
        check("mid_rst_occupancy", 64'(occupancy), 64'(0));
        check("mid_rst_stall_cnt", 64'(stall_cnt), 64'(0));
        mq.delete();
        mstall = 0;
        @(negedge clk);
        rst = 1'b0;

        // Random handshake traffic with occasional flush
        for (int i = 0; i < 10000; i++) begin
            step(1'($urandom_range(0, 1)), DATA_W'($urandom),
                 1'($urandom_range(0, 99) < 70), 1'($urandom_range(0, 99) < 2));
        end
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);
        @(negedge clk);
        check_outputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
